// File: rtl/fetch_pc_ctrl.sv
// fetch_pc_ctrl: PC / fetch control driving a synchronous instruction memory.
// Ports: clk, rst (async, active-low), stall/redirect/trap/halt controls in;
//   fetch_addr_o (to IM), pc_o, fetch_valid_o, misaligned_o, bad_addr_o,
//   fetch_count_o out.
module fetch_pc_ctrl #(
  parameter logic [31:0] RESET_VECTOR     = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR      = 32'h0000_0100,
  parameter bit          TRAP_ON_MISALIGN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_tgt_i,
  input  logic        trap_i,
  input  logic        halt_i,
  output logic [31:0] fetch_addr_o,
  output logic [31:0] pc_o,
  output logic        fetch_valid_o,
  output logic        misaligned_o,
  output logic [31:0] bad_addr_o,
  output logic [31:0] fetch_count_o
);

  localparam logic [1:0] RUN   = 2'd0;
  localparam logic [1:0] HALT  = 2'd1;
  localparam logic [1:0] FAULT = 2'd2;

  logic [1:0]  state_q;
  logic [1:0]  nxt_state;
  logic [31:0] pc_q;
  logic [31:0] nxt_addr;
  logic        valid_q;
  logic        mis_q;
  logic [31:0] bad_q;
  logic [31:0] cnt_q;
  logic        misalign;
  logic        accept;
  logic        cnt_en;

  assign misalign = redirect_i & (|redirect_tgt_i[1:0]);

  always_comb begin
    nxt_addr  = pc_q;
    nxt_state = state_q;
    accept    = 1'b0;
    case (state_q)
      RUN: begin
        accept = 1'b1;
        if (trap_i) begin
          nxt_addr = TRAP_VECTOR;
        end else if (misalign && TRAP_ON_MISALIGN) begin
          nxt_addr = TRAP_VECTOR;
        end else if (misalign) begin
          nxt_state = FAULT;
        end else if (redirect_i) begin
          nxt_addr = redirect_tgt_i;
        end else if (halt_i) begin
          nxt_state = HALT;
        end else if (!stall_i) begin
          nxt_addr = pc_q + 32'd4;
        end
      end
      HALT: begin
        // Only trap or a redirect wakes a halted fetch; stall is moot.
        accept = 1'b1;
        if (trap_i) begin
          nxt_addr  = TRAP_VECTOR;
          nxt_state = RUN;
        end else if (misalign && TRAP_ON_MISALIGN) begin
          nxt_addr  = TRAP_VECTOR;
          nxt_state = RUN;
        end else if (misalign) begin
          nxt_state = FAULT;
        end else if (redirect_i) begin
          nxt_addr  = redirect_tgt_i;
          nxt_state = RUN;
        end
      end
      FAULT: begin
        if (trap_i) begin
          nxt_addr  = TRAP_VECTOR;
          nxt_state = RUN;
        end
      end
      default: nxt_state = RUN;
    endcase
  end

  // IM ignores its address while in reset (it forces word 0), so the
  // next sequential address is presented to line up with the first edge.
  assign fetch_addr_o = rst ? nxt_addr : RESET_VECTOR + 32'd4;

  assign cnt_en = valid_q & (state_q == RUN) & ~stall_i & ~halt_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q    <= RESET_VECTOR;
      state_q <= RUN;
      valid_q <= 1'b1;
      mis_q   <= 1'b0;
      bad_q   <= 32'd0;
      cnt_q   <= 32'd0;
    end else begin
      pc_q    <= fetch_addr_o;
      state_q <= nxt_state;
      valid_q <= (nxt_state == RUN);
      mis_q   <= accept & misalign;
      if (accept && misalign) begin
        bad_q <= redirect_tgt_i;
      end
      if (cnt_en) begin
        cnt_q <= cnt_q + 32'd1;
      end
    end
  end

  assign pc_o          = pc_q;
  assign fetch_valid_o = valid_q;
  assign misaligned_o  = mis_q;
  assign bad_addr_o    = bad_q;
  assign fetch_count_o = cnt_q;

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// tb_fetch_pc_ctrl: directed vectors with a scoreboard queue for fetch_pc_ctrl.
// Two instances share stimulus: u_t traps on misalign, u_f faults.
module tb_fetch_pc_ctrl;

  logic        clk;
  logic        rst;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_tgt_i;
  logic        trap_i;
  logic        halt_i;

  logic [31:0] fa_t, pc_t, bad_t, cnt_t;
  logic        v_t, m_t;
  logic [31:0] fa_f, pc_f, bad_f, cnt_f;
  logic        v_f, m_f;

  fetch_pc_ctrl #(.TRAP_ON_MISALIGN(1'b1)) u_t (
    .clk(clk), .rst(rst), .stall_i(stall_i),
    .redirect_i(redirect_i), .redirect_tgt_i(redirect_tgt_i),
    .trap_i(trap_i), .halt_i(halt_i),
    .fetch_addr_o(fa_t), .pc_o(pc_t), .fetch_valid_o(v_t),
    .misaligned_o(m_t), .bad_addr_o(bad_t), .fetch_count_o(cnt_t)
  );

  fetch_pc_ctrl #(.TRAP_ON_MISALIGN(1'b0)) u_f (
    .clk(clk), .rst(rst), .stall_i(stall_i),
    .redirect_i(redirect_i), .redirect_tgt_i(redirect_tgt_i),
    .trap_i(trap_i), .halt_i(halt_i),
    .fetch_addr_o(fa_f), .pc_o(pc_f), .fetch_valid_o(v_f),
    .misaligned_o(m_f), .bad_addr_o(bad_f), .fetch_count_o(cnt_f)
  );

  typedef struct {
    int          id;
    bit          sel_f;
    logic [31:0] fa;
    logic [31:0] pc;
    logic        v;
    logic        m;
    logic [31:0] bad;
    logic [31:0] cnt;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   vec_id   = 0;
  bit   sel_f    = 1'b0;
  bit   done     = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int id,
                     input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s vec=%0d actual=%h required=%h", nm, id, act, req);
    end
  endtask

  // Monitor: outputs are sampled mid-low-phase, away from the rising edge.
  initial begin
    exp_t e;
    while (!done) begin
      @(negedge clk);
      #2;
      while (q.size() > 0) begin
        e = q.pop_front();
        if (e.sel_f) begin
          chk("fetch_addr", e.id, fa_f, e.fa);
          chk("pc", e.id, pc_f, e.pc);
          chk("valid", e.id, {31'd0, v_f}, {31'd0, e.v});
          chk("misaligned", e.id, {31'd0, m_f}, {31'd0, e.m});
          chk("bad_addr", e.id, bad_f, e.bad);
          chk("count", e.id, cnt_f, e.cnt);
        end else begin
          chk("fetch_addr", e.id, fa_t, e.fa);
          chk("pc", e.id, pc_t, e.pc);
          chk("valid", e.id, {31'd0, v_t}, {31'd0, e.v});
          chk("misaligned", e.id, {31'd0, m_t}, {31'd0, e.m});
          chk("bad_addr", e.id, bad_t, e.bad);
          chk("count", e.id, cnt_t, e.cnt);
        end
      end
    end
  end

  // One cycle: apply inputs after the falling edge, queue what the
  // selected instance must show before the next rising edge.
  task automatic step(
    input logic r, input logic st, input logic rd,
    input logic [31:0] tg, input logic tr, input logic hl,
    input logic [31:0] efa, input logic [31:0] epc, input logic ev,
    input logic em, input logic [31:0] ebad, input logic [31:0] ecnt);
    exp_t e;
    @(negedge clk);
    rst            = r;
    stall_i        = st;
    redirect_i     = rd;
    redirect_tgt_i = tg;
    trap_i         = tr;
    halt_i         = hl;
    e.id    = vec_id;
    e.sel_f = sel_f;
    e.fa    = efa;
    e.pc    = epc;
    e.v     = ev;
    e.m     = em;
    e.bad   = ebad;
    e.cnt   = ecnt;
    q.push_back(e);
    vec_id++;
  endtask

  initial begin
    rst = 1'b0; stall_i = 1'b0; redirect_i = 1'b0;
    redirect_tgt_i = 32'd0; trap_i = 1'b0; halt_i = 1'b0;

    //   rst st rd tgt           tr hl  fa            pc            v  m  bad    cnt
    step(0, 0, 0, 32'h0,        0, 0, 32'h4,        32'h0,        1, 0, 32'h0,  0);
    step(1, 0, 0, 32'h0,        0, 0, 32'h4,        32'h0,        1, 0, 32'h0,  0);
    step(1, 0, 0, 32'h0,        0, 0, 32'h8,        32'h4,        1, 0, 32'h0,  1);
    step(1, 0, 0, 32'h0,        0, 0, 32'hC,        32'h8,        1, 0, 32'h0,  2);
    step(1, 0, 0, 32'h0,        0, 0, 32'h10,       32'hC,        1, 0, 32'h0,  3);
    // stall three cycles at 0x10
    step(1, 1, 0, 32'h0,        0, 0, 32'h10,       32'h10,       1, 0, 32'h0,  4);
    step(1, 1, 0, 32'h0,        0, 0, 32'h10,       32'h10,       1, 0, 32'h0,  4);
    step(1, 1, 0, 32'h0,        0, 0, 32'h10,       32'h10,       1, 0, 32'h0,  4);
    step(1, 0, 0, 32'h0,        0, 0, 32'h14,       32'h10,       1, 0, 32'h0,  4);
    // redirect beats stall
    step(1, 1, 1, 32'h2C,       0, 0, 32'h2C,       32'h14,       1, 0, 32'h0,  5);
    step(1, 0, 0, 32'h0,        0, 0, 32'h30,       32'h2C,       1, 0, 32'h0,  5);
    // misaligned redirect traps
    step(1, 0, 1, 32'h2E,       0, 0, 32'h100,      32'h30,       1, 0, 32'h0,  6);
    step(1, 0, 0, 32'h0,        0, 0, 32'h104,      32'h100,      1, 1, 32'h2E, 7);
    step(1, 0, 0, 32'h0,        0, 0, 32'h108,      32'h104,      1, 0, 32'h2E, 8);
    // plain trap in RUN
    step(1, 0, 0, 32'h0,        1, 0, 32'h100,      32'h108,      1, 0, 32'h2E, 9);
    step(1, 0, 0, 32'h0,        0, 0, 32'h104,      32'h100,      1, 0, 32'h2E, 10);
    step(1, 0, 1, 32'h30,       0, 0, 32'h30,       32'h104,      1, 0, 32'h2E, 11);
    step(1, 0, 0, 32'h0,        0, 0, 32'h34,       32'h30,       1, 0, 32'h2E, 12);
    step(1, 0, 0, 32'h0,        0, 0, 32'h38,       32'h34,       1, 0, 32'h2E, 13);
    // halt at 0x38; stall ignored; trap resumes
    step(1, 0, 0, 32'h0,        0, 1, 32'h38,       32'h38,       1, 0, 32'h2E, 14);
    step(1, 0, 0, 32'h0,        0, 0, 32'h38,       32'h38,       0, 0, 32'h2E, 14);
    step(1, 1, 0, 32'h0,        0, 0, 32'h38,       32'h38,       0, 0, 32'h2E, 14);
    step(1, 0, 0, 32'h0,        1, 0, 32'h100,      32'h38,       0, 0, 32'h2E, 14);
    step(1, 0, 0, 32'h0,        0, 0, 32'h104,      32'h100,      1, 0, 32'h2E, 14);
    // halt again, then async reset mid-HALT
    step(1, 0, 0, 32'h0,        0, 1, 32'h104,      32'h104,      1, 0, 32'h2E, 15);
    step(0, 0, 0, 32'h0,        0, 0, 32'h4,        32'h0,        1, 0, 32'h0,  0);
    step(1, 0, 0, 32'h0,        0, 0, 32'h4,        32'h0,        1, 0, 32'h0,  0);
    // 32-bit wrap of the sequential address
    step(1, 0, 1, 32'hFFFF_FFFC, 0, 0, 32'hFFFF_FFFC, 32'h4,      1, 0, 32'h0,  1);
    step(1, 0, 0, 32'h0,        0, 0, 32'h0,        32'hFFFF_FFFC, 1, 0, 32'h0, 2);
    step(1, 0, 0, 32'h0,        0, 0, 32'h4,        32'h0,        1, 0, 32'h0,  3);

    // fault-on-misalign instance
    sel_f = 1'b1;
    step(0, 0, 0, 32'h0,        0, 0, 32'h4,        32'h0,        1, 0, 32'h0,  0);
    step(1, 0, 0, 32'h0,        0, 0, 32'h4,        32'h0,        1, 0, 32'h0,  0);
    step(1, 0, 0, 32'h0,        0, 0, 32'h8,        32'h4,        1, 0, 32'h0,  1);
    step(1, 0, 1, 32'h2E,       0, 0, 32'h8,        32'h8,        1, 0, 32'h0,  2);
    step(1, 0, 1, 32'h41,       0, 0, 32'h8,        32'h8,        0, 1, 32'h2E, 3);
    step(1, 1, 0, 32'h0,        0, 1, 32'h8,        32'h8,        0, 0, 32'h2E, 3);
    step(1, 0, 0, 32'h0,        1, 0, 32'h100,      32'h8,        0, 0, 32'h2E, 3);
    step(1, 0, 0, 32'h0,        0, 0, 32'h104,      32'h100,      1, 0, 32'h2E, 3);
    step(1, 0, 0, 32'h0,        0, 0, 32'h108,      32'h104,      1, 0, 32'h2E, 4);

    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d required=0", q.size());
    end
    done = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
